// File: rtl/sparse_chunk_sram_rx.sv
// Chunk-organised receive buffer for the compressed SRAM write stream; tracks per-chunk completion and counts.
// Read latency 1 cycle, writes take effect at the edge; no backpressure on either port, bad beats are dropped and flagged.
module sparse_chunk_sram_rx #(
    parameter int BUS_SIZE       = 32,
    parameter int DAT_SIZE       = 8,
    parameter int WR_DAT_CYC_NUM = 8,
    parameter int CHUNK_NUM      = 16
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        wr_valid_i,
    input  logic [BUS_SIZE-1:0]                         wr_sparsemap_i,
    input  logic [BUS_SIZE*DAT_SIZE-1:0]                wr_nonzero_data_i,
    input  logic [$clog2(WR_DAT_CYC_NUM)-1:0]           wr_dat_count_i,
    input  logic [$clog2(CHUNK_NUM)-1:0]                wr_chunk_count_i,
    input  logic                                        wr_finish_i,
    input  logic                                        rd_req_i,
    input  logic [$clog2(CHUNK_NUM)-1:0]                rd_chunk_i,
    input  logic [$clog2(WR_DAT_CYC_NUM)-1:0]           rd_dat_i,
    output logic                                        rd_valid_o,
    output logic                                        rd_hit_o,
    output logic [BUS_SIZE-1:0]                         rd_sparsemap_o,
    output logic [BUS_SIZE*DAT_SIZE-1:0]                rd_nonzero_data_o,
    output logic [$clog2(BUS_SIZE*WR_DAT_CYC_NUM+1)-1:0] rd_nnz_o,
    output logic [CHUNK_NUM-1:0]                        chunk_done_o,
    output logic                                        all_done_o,
    output logic                                        seq_err_o
);

    localparam int DW    = $clog2(WR_DAT_CYC_NUM);
    localparam int CW    = $clog2(CHUNK_NUM);
    localparam int BW    = $clog2(WR_DAT_CYC_NUM + 1);
    localparam int NW    = $clog2(BUS_SIZE * WR_DAT_CYC_NUM + 1);
    localparam int PW    = $clog2(BUS_SIZE + 1);
    localparam int DATW  = BUS_SIZE * DAT_SIZE;
    localparam int DEPTH = CHUNK_NUM * WR_DAT_CYC_NUM;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [DW-1:0] LAST_BEAT = DW'(WR_DAT_CYC_NUM - 1);
    localparam logic [CW:0]   CHUNK_LIM = (CW + 1)'(CHUNK_NUM);

    typedef enum logic {S_IDLE, S_OPEN} state_t;

    function automatic logic [PW-1:0] popcnt(input logic [BUS_SIZE-1:0] v);
        logic [PW-1:0] s;
        s = '0;
        for (int i = 0; i < BUS_SIZE; i++) s = s + PW'(v[i]);
        return s;
    endfunction

    state_t          state_q;
    logic [CW-1:0]   cur_q;
    logic [DW-1:0]   exp_q;
    logic [CHUNK_NUM-1:0] done_q;
    logic [BW-1:0]   bcnt_q [CHUNK_NUM];
    logic [NW-1:0]   nnz_q  [CHUNK_NUM];
    logic            err_q;

    logic [BUS_SIZE-1:0] sm_mem  [DEPTH];
    logic [DATW-1:0]     dat_mem [DEPTH];

    logic          in_range, match, start, append, drop, close_cur, start_close;
    logic [PW-1:0] wr_pop;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          rd_hit_c;

    assign in_range = {1'b0, wr_chunk_count_i} < CHUNK_LIM;
    assign match    = (state_q == S_OPEN) && (wr_chunk_count_i == cur_q);
    // A beat for any other slot is handled as if no chunk were open, after closing the current one.
    assign start    = wr_valid_i && !match && (wr_dat_count_i == '0) && in_range;
    assign append   = wr_valid_i && match && (wr_dat_count_i == exp_q);
    assign drop     = wr_valid_i && !start && !append;
    assign close_cur = (state_q == S_OPEN) &&
                       (!wr_valid_i || wr_finish_i || !match || (append && wr_dat_count_i == LAST_BEAT));
    assign start_close = start && ((wr_dat_count_i == LAST_BEAT) || wr_finish_i);
    assign wr_pop   = popcnt(wr_sparsemap_i);
    assign wr_addr  = AW'(wr_chunk_count_i) * AW'(WR_DAT_CYC_NUM) + AW'(wr_dat_count_i);
    assign rd_addr  = AW'(rd_chunk_i) * AW'(WR_DAT_CYC_NUM) + AW'(rd_dat_i);
    assign rd_hit_c = done_q[rd_chunk_i] && (BW'(rd_dat_i) < bcnt_q[rd_chunk_i]);

    always_ff @(posedge clk_i) begin
        if (start || append) begin
            sm_mem[wr_addr]  <= wr_sparsemap_i;
            dat_mem[wr_addr] <= wr_nonzero_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            exp_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < CHUNK_NUM; i++) begin
                bcnt_q[i] <= '0;
                nnz_q[i]  <= '0;
            end
        end else begin
            if (drop) err_q <= 1'b1;
            if (close_cur) done_q[cur_q] <= 1'b1;
            if (start) begin
                done_q[wr_chunk_count_i] <= start_close;
                bcnt_q[wr_chunk_count_i] <= BW'(1);
                nnz_q[wr_chunk_count_i]  <= NW'(wr_pop);
                cur_q   <= wr_chunk_count_i;
                exp_q   <= DW'(1);
                state_q <= start_close ? S_IDLE : S_OPEN;
            end else if (append) begin
                bcnt_q[cur_q] <= bcnt_q[cur_q] + BW'(1);
                nnz_q[cur_q]  <= nnz_q[cur_q] + NW'(wr_pop);
                exp_q         <= exp_q + DW'(1);
                if (close_cur) state_q <= S_IDLE;
            end else if (close_cur) begin
                state_q <= S_IDLE;
            end
        end
    end

    // Reads see pre-edge storage and flags, so a same-cycle rewrite is invisible until it closes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_valid_o        <= 1'b0;
            rd_hit_o          <= 1'b0;
            rd_sparsemap_o    <= '0;
            rd_nonzero_data_o <= '0;
            rd_nnz_o          <= '0;
        end else begin
            rd_valid_o        <= rd_req_i;
            rd_hit_o          <= rd_req_i && rd_hit_c;
            rd_sparsemap_o    <= (rd_req_i && rd_hit_c) ? sm_mem[rd_addr] : '0;
            rd_nonzero_data_o <= (rd_req_i && rd_hit_c) ? dat_mem[rd_addr] : '0;
            rd_nnz_o          <= (rd_req_i && rd_hit_c) ? nnz_q[rd_chunk_i] : '0;
        end
    end

    assign chunk_done_o = done_q;
    assign all_done_o   = &done_q;
    assign seq_err_o    = err_q;

endmodule

// File: tb/tb_sparse_chunk_sram_rx.sv
// Randomised and directed bench for sparse_chunk_sram_rx against a slot-array reference model.
module tb_sparse_chunk_sram_rx;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         wr_valid_i;
    logic [31:0]  wr_sparsemap_i;
    logic [255:0] wr_nonzero_data_i;
    logic [2:0]   wr_dat_count_i;
    logic [3:0]   wr_chunk_count_i;
    logic         wr_finish_i;
    logic         rd_req_i;
    logic [3:0]   rd_chunk_i;
    logic [2:0]   rd_dat_i;
    logic         rd_valid_o, rd_hit_o;
    logic [31:0]  rd_sparsemap_o;
    logic [255:0] rd_nonzero_data_o;
    logic [8:0]   rd_nnz_o;
    logic [15:0]  chunk_done_o;
    logic         all_done_o, seq_err_o;

    sparse_chunk_sram_rx dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wr_valid_i(wr_valid_i), .wr_sparsemap_i(wr_sparsemap_i),
        .wr_nonzero_data_i(wr_nonzero_data_i), .wr_dat_count_i(wr_dat_count_i),
        .wr_chunk_count_i(wr_chunk_count_i), .wr_finish_i(wr_finish_i),
        .rd_req_i(rd_req_i), .rd_chunk_i(rd_chunk_i), .rd_dat_i(rd_dat_i),
        .rd_valid_o(rd_valid_o), .rd_hit_o(rd_hit_o), .rd_sparsemap_o(rd_sparsemap_o),
        .rd_nonzero_data_o(rd_nonzero_data_o), .rd_nnz_o(rd_nnz_o),
        .chunk_done_o(chunk_done_o), .all_done_o(all_done_o), .seq_err_o(seq_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one record per slot, plus the currently open slot (or none).
    logic [31:0]  m_sm  [16][8];
    logic [255:0] m_dat [16][8];
    bit           m_done[16];
    int           m_bcnt[16];
    int           m_nnz [16];
    bit           m_open;
    int           m_cur, m_exp;
    bit           m_err;

    logic         e_valid, e_hit;
    logic [31:0]  e_sm;
    logic [255:0] e_dat;
    int           e_nnz;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd_dat();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic m_close();
        if (m_open) begin
            m_done[m_cur] = 1'b1;
            m_open = 1'b0;
        end
    endtask

    task automatic m_store(input int c, input int d);
        m_sm[c][d]  = wr_sparsemap_i;
        m_dat[c][d] = wr_nonzero_data_i;
    endtask

    task automatic model_edge();
        int c, d;
        c = int'(wr_chunk_count_i);
        d = int'(wr_dat_count_i);
        e_valid = 1'b0; e_hit = 1'b0; e_sm = '0; e_dat = '0; e_nnz = 0;
        if (!rst_i) begin
            for (int i = 0; i < 16; i++) begin
                m_done[i] = 1'b0; m_bcnt[i] = 0; m_nnz[i] = 0;
            end
            m_open = 1'b0; m_err = 1'b0; m_cur = 0; m_exp = 0;
            return;
        end
        if (rd_req_i) begin
            e_valid = 1'b1;
            if (m_done[rd_chunk_i] && int'(rd_dat_i) < m_bcnt[rd_chunk_i]) begin
                e_hit = 1'b1;
                e_sm  = m_sm[rd_chunk_i][rd_dat_i];
                e_dat = m_dat[rd_chunk_i][rd_dat_i];
                e_nnz = m_nnz[rd_chunk_i];
            end
        end
        if (!wr_valid_i) begin
            m_close();
        end else if (m_open && c == m_cur) begin
            if (d == m_exp) begin
                m_store(c, d);
                m_bcnt[c]++;
                m_nnz[c] += $countones(wr_sparsemap_i);
                m_exp++;
                if (d == 7 || wr_finish_i) m_close();
            end else begin
                m_err = 1'b1;
                if (wr_finish_i) m_close();
            end
        end else begin
            m_close();
            if (d == 0) begin
                m_store(c, 0);
                m_done[c] = 1'b0;
                m_bcnt[c] = 1;
                m_nnz[c]  = $countones(wr_sparsemap_i);
                m_open = 1'b1; m_cur = c; m_exp = 1;
                if (wr_finish_i) m_close();
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic step();
        logic [15:0] e_done;
        model_edge();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 16; i++) e_done[i] = m_done[i];
        chk("rd_valid", rd_valid_o, e_valid);
        chk("rd_hit", rd_hit_o, e_hit);
        chk("rd_sparsemap", rd_sparsemap_o, e_sm);
        chk("rd_data", rd_nonzero_data_o, e_dat);
        chk("rd_nnz", rd_nnz_o, 9'(e_nnz));
        chk("chunk_done", chunk_done_o, e_done);
        chk("all_done", all_done_o, &e_done);
        chk("seq_err", seq_err_o, m_err);
    endtask

    task automatic cyc(input bit v, input int c, input int d, input logic [31:0] sm,
                       input bit fin, input bit rq, input int rc, input int rd);
        rst_i = 1'b1;
        wr_valid_i = v; wr_chunk_count_i = 4'(c); wr_dat_count_i = 3'(d);
        wr_sparsemap_i = sm; wr_nonzero_data_i = rnd_dat();
        wr_finish_i = fin; rd_req_i = rq; rd_chunk_i = 4'(rc); rd_dat_i = 3'(rd);
        step();
    endtask

    task automatic do_reset();
        rst_i = 1'b0; wr_valid_i = 1'b0; wr_finish_i = 1'b0; rd_req_i = 1'b0;
        step();
    endtask

    initial begin
        int cc, cd, r;
        rst_i = 1'b0; wr_valid_i = 1'b0; wr_sparsemap_i = '0; wr_nonzero_data_i = '0;
        wr_dat_count_i = '0; wr_chunk_count_i = '0; wr_finish_i = 1'b0;
        rd_req_i = 1'b0; rd_chunk_i = '0; rd_dat_i = '0;
        do_reset();
        do_reset();
        chk("reset_done", chunk_done_o, 16'h0);

        // Full 8-beat chunk closes on its last beat.
        for (int i = 0; i < 8; i++) cyc(1, 3, i, 32'h0000_00FF, 0, 0, 0, 0);
        chk("t1_done3", chunk_done_o[3], 1'b1);
        cyc(0, 0, 0, 0, 0, 1, 3, 5);
        chk("t1_hit", rd_hit_o, 1'b1);
        chk("t1_nnz64", rd_nnz_o, 9'd64);

        // Short chunk closed by valid dropping.
        for (int i = 0; i < 3; i++) cyc(1, 2, i, $urandom, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 2, 2);
        cyc(0, 0, 0, 0, 0, 1, 2, 2);
        chk("t2_hit22", rd_hit_o, 1'b1);
        cyc(0, 0, 0, 0, 0, 1, 2, 3);
        chk("t2_miss23", rd_hit_o, 1'b0);

        // Switching slots closes the open one in the same cycle.
        cyc(1, 0, 0, $urandom, 0, 0, 0, 0);
        cyc(1, 0, 1, $urandom, 0, 0, 0, 0);
        cyc(1, 1, 0, $urandom, 0, 0, 0, 0);
        chk("t3_done0", chunk_done_o[0], 1'b1);
        chk("t3_noerr", seq_err_o, 1'b0);
        cyc(0, 0, 0, 0, 0, 1, 0, 1);

        // Out-of-order beat is dropped and flagged; the chunk continues.
        cyc(1, 4, 0, $urandom, 0, 0, 0, 0);
        cyc(1, 4, 1, $urandom, 0, 0, 0, 0);
        cyc(1, 4, 3, $urandom, 0, 0, 0, 0);
        cyc(1, 4, 2, $urandom, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 4, 3);
        cyc(0, 0, 0, 0, 0, 1, 4, 2);
        chk("t4_err", seq_err_o, 1'b1);

        // Read-before-write on a slot being rewritten.
        cyc(1, 5, 0, $urandom, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 5, 0, $urandom, 0, 1, 5, 0);
        cyc(0, 0, 0, 0, 1, 1, 5, 0);
        cyc(0, 0, 0, 0, 0, 1, 5, 0);

        // Reset with chunk 6 open discards it.
        for (int i = 0; i < 5; i++) cyc(1, 6, i, $urandom, 0, 0, 0, 0);
        do_reset();
        chk("t6_done_clr", chunk_done_o, 16'h0);
        cyc(1, 6, 0, $urandom, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t6_done6", chunk_done_o[6], 1'b1);

        // Random mix of mostly in-order streams, stray beats, finishes, resets and reads.
        cc = 0; cd = -1;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
                cd = -1;
            end else if (r < 72) begin
                if (cd < 0 || cd >= 8 || $urandom_range(0, 5) == 0) begin
                    cc = $urandom_range(0, 15);
                    cd = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
                end
                cyc(1, cc, cd, $urandom & $urandom, 0, $urandom_range(0, 1),
                    $urandom_range(0, 15), $urandom_range(0, 7));
                cd++;
            end else begin
                cyc(0, 0, 0, 0, r < 82, $urandom_range(0, 1),
                    $urandom_range(0, 15), $urandom_range(0, 7));
                cd = -1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sparse_chunk_sram_rx.md
Name: sparse_chunk_sram_rx

Overview:
Receiving end of the compressed-chunk SRAM write stream: accepts per-beat sparsemap and nonzero-data words tagged with data-beat and chunk indices, and stores them in a chunk-organised buffer. It tracks per-chunk completion, beat count and nonzero count, and flags protocol errors. A 1-cycle-latency read port lets the compute side fetch any beat of a completed chunk. One instance sits behind each of the IFM and filter write streams.

Parameters:
BUS_SIZE, 32, sparsemap bits per beat; nonzero-data beat width is BUS_SIZE*DAT_SIZE
DAT_SIZE, 8, bits per data element
WR_DAT_CYC_NUM, 8, maximum beats per chunk
CHUNK_NUM, 16, number of chunk slots

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-low
wr_valid_i  in  1  write beat valid
wr_sparsemap_i  in  BUS_SIZE  sparsemap beat
wr_nonzero_data_i  in  BUS_SIZE*DAT_SIZE  nonzero-data beat
wr_dat_count_i  in  $clog2(WR_DAT_CYC_NUM)  beat index within the chunk
wr_chunk_count_i  in  $clog2(CHUNK_NUM)  chunk slot index
wr_finish_i  in  1  end-of-stream pulse
rd_req_i  in  1  read request
rd_chunk_i  in  $clog2(CHUNK_NUM)  read chunk slot
rd_dat_i  in  $clog2(WR_DAT_CYC_NUM)  read beat index
rd_valid_o  out  1  read response valid, 1 cycle after rd_req_i
rd_hit_o  out  1  requested chunk was complete and beat < stored beat count
rd_sparsemap_o  out  BUS_SIZE  read sparsemap
rd_nonzero_data_o  out  BUS_SIZE*DAT_SIZE  read nonzero data
rd_nnz_o  out  $clog2(BUS_SIZE*WR_DAT_CYC_NUM+1)  nonzero count of the requested chunk
chunk_done_o  out  CHUNK_NUM  per-slot complete flags
all_done_o  out  1  all slots complete
seq_err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst_i==0 at a clk_i edge): all rd_* outputs 0, chunk_done_o 0, all_done_o 0, seq_err_o 0, no chunk open, per-slot beat and nnz counters 0. Storage contents are not cleared.
- Write FSM states: IDLE (no open chunk) and OPEN (chunk C open, next expected beat E).
- IDLE, wr_valid_i with dat_count==0:
  - Store the beat at [chunk][0].
  - Clear done[chunk], set beat_cnt=1, set nnz=popcount(sparsemap).
  - Go to OPEN with C=chunk, E=1.
- IDLE, wr_valid_i with dat_count!=0: drop the beat, set seq_err_o.
- OPEN, wr_valid_i with chunk==C and dat_count==E: store the beat, beat_cnt+=1, nnz+=popcount, E+=1.
- OPEN, wr_valid_i with chunk!=C: close C, then treat the beat exactly as in IDLE in the same cycle.
- OPEN, wr_valid_i with chunk==C and dat_count!=E: drop the beat, set seq_err_o, stay in OPEN.
- Closing a chunk: done[C]=1; beat_cnt and nnz are frozen. Close triggers:
  - Acceptance of the beat with dat_count==WR_DAT_CYC_NUM-1, which returns the FSM to IDLE.
  - wr_valid_i==0 while OPEN.
  - wr_finish_i==1 while OPEN.
- chunk_done_o and all_done_o update on the edge that closes the chunk and are visible the next cycle.
- A chunk is rewritten only when its dat_count==0 beat is accepted; that beat clears its done flag.
- Read port:
  - rd_req_i sampled at an edge gives rd_valid_o=1 for exactly one cycle after that edge.
  - Hit (done[rd_chunk_i]==1 and rd_dat_i < beat_cnt): rd_hit_o=1, outputs the stored beat and rd_nnz_o.
  - Miss: rd_hit_o=0 and sparsemap, data and nnz outputs are 0.
  - With no request, all rd_* outputs return to 0.
- Same-cycle write and read to the same slot: the read returns pre-edge contents and pre-edge done/beat_cnt (read-before-write).
- Back-to-back reads are allowed every cycle, with no backpressure.
- Reset mid-chunk: the open chunk is discarded and not marked done.
- Index wrap: dat_count and chunk_count are used as-is. Software guarantees chunk_count < CHUNK_NUM; any value ≥ CHUNK_NUM is dropped and sets seq_err_o.
- seq_err_o clears only on reset.

Test Plan:
1. Chunk 3, 8 beats dat 0..7, each sparsemap 0x0000_00FF, then wr_valid_i=0 → chunk_done_o[3]=1 one cycle after beat 7; a read of (3,5) gives rd_hit_o=1, the written data and rd_nnz_o=64.
2. Chunk 2, 3 beats (ceil-size IFM chunk), then wr_valid_i drops → done[2]=1, beat_cnt 3; read (2,2) is a hit; read (2,3) gives rd_hit_o=0 and zeros.
3. Chunk 0 beats 0,1 immediately followed by chunk 1 beat 0 → chunk 0 closes with beat_cnt 2, chunk 1 opens in the same cycle, no error.
4. Chunk 4 beats 0,1,3 → beat 3 is dropped, seq_err_o=1 sticky; a following beat 2 is accepted; a read of (4,3) after close misses.
5. Read (5,0) in the same cycle chunk 5 beat 0 is written, with chunk 5 previously done holding data A → response shows A; the next read shows the new data only after the chunk closes.
6. Assert rst_i=0 while chunk 6 is OPEN at beat 4 → all outputs 0; done[6]=0 after release; a new dat 0 beat to chunk 6 is accepted normally.
